ps2_host_tx: RTL

//  PS/2 host-to-device transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard.

---
 rtl/ps2_host_tx.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, requests to send, then shifts one byte plus odd parity out on device clocks.
// Optional device-clock watchdog is compiled in with `define PS2_TX_TIMEOUT_EN.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | lines released, waiting for tx_start
// INHIBIT   | clock held low for INHIBIT_CYCLES
// REQ       | start bit driven, clock released, waiting for first device edge
// SEND      | shifting data/parity/stop on device falling edges, ACK on the 11th
// WAIT_IDLE | lines released, waiting for clock and data both high
module ps2_host_tx #(
   parameter int CLK_HZ         = 100_000_000,
   parameter int INHIBIT_US     = 100,
   parameter int TIMEOUT_CYCLES = 200_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_err
);

   localparam int INHIBIT_CYCLES = CLK_HZ / 1_000_000 * INHIBIT_US;
   localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
   localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYCLES - 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_INHIBIT   = 3'd1;
   localparam logic [2:0] S_REQ       = 3'd2;
   localparam logic [2:0] S_SEND      = 3'd3;
   localparam logic [2:0] S_WAIT_IDLE = 3'd4;

   logic [2:0]       state;
   logic [INH_W-1:0] inh_cnt;
   logic [3:0]       bit_cnt;
   logic [8:0]       shreg;
   logic [1:0]       clk_sync;
   logic [1:0]       data_sync;
   logic             clk_prev;
   logic             clk_s;
   logic             data_s;
   logic             fe;
   logic             wd_fire;

   assign clk_s  = clk_sync[1];
   assign data_s = data_sync[1];
   assign fe     = clk_prev & ~clk_s;

   // Synchronisers reset to the idle-high bus level so no edge is seen on release of rst.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
         clk_prev  <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk_in};
         data_sync <= {data_sync[0], ps2_data_in};
         clk_prev  <= clk_s;
      end
   end

`ifdef PS2_TX_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_cnt;
   logic            wd_active;

   assign wd_active = (state == S_REQ) || (state == S_SEND) ||
                      ((state == S_WAIT_IDLE) && !(clk_s && data_s));

   // Reloaded during INHIBIT so the count starts fresh on entry to REQ.
   always_ff @(posedge clk) begin
      if (rst)
         wd_cnt <= '0;
      else if ((state == S_INHIBIT) || fe)
         wd_cnt <= WD_W'(TIMEOUT_CYCLES - 1);
      else if (wd_active && (wd_cnt != '0))
         wd_cnt <= wd_cnt - 1'b1;
   end

   assign wd_fire = wd_active && !fe && (wd_cnt == WD_W'(1));
`else
   assign wd_fire = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         inh_cnt     <= '0;
         bit_cnt     <= '0;
         shreg       <= '0;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
         tx_busy     <= 1'b0;
         tx_done     <= 1'b0;
         tx_err      <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         if (wd_fire) begin
            state       <= S_IDLE;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b1;
            tx_err      <= 1'b1;
         end else begin
            case (state)
               S_IDLE: begin
                  if (tx_start) begin
                     shreg      <= {~^tx_data, tx_data};
                     tx_busy    <= 1'b1;
                     tx_err     <= 1'b0;
                     ps2_clk_oe <= 1'b1;
                     inh_cnt    <= INH_LOAD;
                     state      <= S_INHIBIT;
                  end
               end
               S_INHIBIT: begin
                  if (inh_cnt == '0) begin
                     ps2_clk_oe  <= 1'b0;
                     ps2_data_oe <= 1'b1;
                     bit_cnt     <= '0;
                     state       <= S_REQ;
                  end else begin
                     inh_cnt <= inh_cnt - 1'b1;
                  end
               end
               S_REQ, S_SEND: begin
                  if (fe) begin
                     bit_cnt <= bit_cnt + 4'd1;
                     state   <= S_SEND;
                     // Edges 1..9 shift out data LSB first then parity; 10 releases for stop; 11 reads ACK.
                     if (bit_cnt < 4'd9) begin
                        ps2_data_oe <= ~shreg[0];
                        shreg       <= {1'b0, shreg[8:1]};
                     end else if (bit_cnt == 4'd9) begin
                        ps2_data_oe <= 1'b0;
                     end else begin
                        tx_err <= data_s;
                        state  <= S_WAIT_IDLE;
                     end
                  end
               end
               S_WAIT_IDLE: begin
                  ps2_clk_oe  <= 1'b0;
                  ps2_data_oe <= 1'b0;
                  if (clk_s && data_s) begin
                     state   <= S_IDLE;
                     tx_busy <= 1'b0;
                     tx_done <= 1'b1;
                  end
               end
               default: begin
                  state       <= S_IDLE;
                  ps2_clk_oe  <= 1'b0;
                  ps2_data_oe <= 1'b0;
                  tx_busy     <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
